rocc_cmd_queue: RTL

Parametrised successor to the single-entry RoCC issue adapter. It buffers up to CMD_DEPTH issued RoCC commands and drives them to the accelerator command channel. It tracks up to MAX_OUTSTANDING response-bearing commands in an in-order tag queue, so each accelerator response is returned to writeback with the correct trans_id. On flush it drops queued commands and suppresses writeback of responses from commands already sent.

---
 rtl/rocc_pkg.sv | 21 ++
 rtl/rocc_fifo.sv | 57 +++++
 rtl/rocc_cmd_queue.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rocc_pkg.sv
// Shared widths and payload types for the RoCC command queue.
package rocc_pkg;

  localparam int unsigned ROCC_XLEN    = 64;
  localparam int unsigned ROCC_TID_W   = 3;
  localparam int unsigned ROCC_INSTR_W = 32;

  typedef struct packed {
    logic [ROCC_XLEN-1:0]    rs1;
    logic [ROCC_XLEN-1:0]    rs2;
    logic [ROCC_INSTR_W-1:0] instr;
    logic                    xd;
    logic [ROCC_TID_W-1:0]   trans_id;
  } rocc_cmd_t;

  typedef struct packed {
    logic [ROCC_TID_W-1:0] trans_id;
    logic                  killed;
  } rocc_tag_t;

endpackage

// File: rtl/rocc_fifo.sv
// Generic synchronous FIFO with flush; storage resets to zero so the head
// never shows X after reset.
module rocc_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == CW'(DEPTH));
  assign count_o = r_cnt;
  assign data_o  = r_mem[r_rp];
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= data_i;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/rocc_cmd_queue.sv
// Buffers issued RoCC commands toward the accelerator and returns responses
// to writeback in order, tagged with their trans_id; flush kills in-flight tags.
module rocc_cmd_queue
  import rocc_pkg::*;
#(
  parameter int unsigned XLEN            = ROCC_XLEN,
  parameter int unsigned TRANS_ID_BITS   = ROCC_TID_W,
  parameter int unsigned CMD_DEPTH       = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [31:0]              instr_i,
  input  logic                     xd_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [XLEN-1:0]          cmd_rs1_o,
  output logic [XLEN-1:0]          cmd_rs2_o,
  output logic [31:0]              cmd_instr_o,
  input  logic                     resp_valid_i,
  output logic                     resp_ready_o,
  input  logic [XLEN-1:0]          resp_data_i,
  output logic                     valid_o,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     busy_o,
  output logic                     spurious_o
);

  localparam int unsigned TAG_AW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned TAG_CW = TAG_AW + 1;

  rocc_cmd_t                    w_push_cmd;
  rocc_cmd_t                    w_head_cmd;
  logic                         w_cmd_full;
  logic                         w_cmd_empty;
  logic [$clog2(CMD_DEPTH):0]   w_cmd_count;
  logic                         w_accept;
  logic                         w_cmd_hs;

  rocc_tag_t                    r_tag_mem [MAX_OUTSTANDING];
  logic [TAG_AW-1:0]            r_tag_wp;
  logic [TAG_AW-1:0]            r_tag_rp;
  logic [TAG_CW-1:0]            r_tag_cnt;
  rocc_tag_t                    w_tag_head;
  logic                         w_tag_empty;
  logic                         w_tag_full;
  logic                         w_tag_push;
  logic                         w_tag_pop;

  always_comb begin
    w_push_cmd          = '0;
    w_push_cmd.rs1      = operand_a_i;
    w_push_cmd.rs2      = operand_b_i;
    w_push_cmd.instr    = instr_i;
    w_push_cmd.xd       = xd_i;
    w_push_cmd.trans_id = trans_id_i;
  end

  assign ready_o  = !w_cmd_full && !flush_i;
  assign w_accept = valid_i && ready_o;

  rocc_fifo #(
    .T     (rocc_cmd_t),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (w_accept),
    .data_i  (w_push_cmd),
    .pop_i   (w_cmd_hs),
    .data_o  (w_head_cmd),
    .full_o  (w_cmd_full),
    .empty_o (w_cmd_empty),
    .count_o (w_cmd_count)
  );

  // A result-bearing command must not issue unless it can reserve a tag slot.
  assign cmd_valid_o = !w_cmd_empty && !(w_head_cmd.xd && w_tag_full);
  assign w_cmd_hs    = cmd_valid_o && cmd_ready_i;
  assign cmd_rs1_o   = w_head_cmd.rs1;
  assign cmd_rs2_o   = w_head_cmd.rs2;
  assign cmd_instr_o = w_head_cmd.instr;

  assign w_tag_head  = r_tag_mem[r_tag_rp];
  assign w_tag_empty = (r_tag_cnt == '0);
  assign w_tag_full  = (r_tag_cnt == TAG_CW'(MAX_OUTSTANDING));
  assign w_tag_push  = w_cmd_hs && w_head_cmd.xd;
  assign w_tag_pop   = resp_valid_i && !w_tag_empty;

  assign resp_ready_o = 1'b1;
  assign valid_o      = w_tag_pop && !w_tag_head.killed && !flush_i;
  assign result_o     = resp_data_i;
  assign trans_id_o   = w_tag_head.trans_id;
  assign spurious_o   = resp_valid_i && w_tag_empty;
  assign busy_o       = (w_cmd_count != '0) || !w_tag_empty;

  // Tag queue; a flush marks every surviving entry killed, and a tag pushed
  // in the flush cycle is born killed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) r_tag_mem[i] <= '0;
      r_tag_wp  <= '0;
      r_tag_rp  <= '0;
      r_tag_cnt <= '0;
    end else begin
      if (flush_i) begin
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) r_tag_mem[i].killed <= 1'b1;
      end
      if (w_tag_push) begin
        r_tag_mem[r_tag_wp] <= '{trans_id: w_head_cmd.trans_id, killed: flush_i};
        r_tag_wp            <= r_tag_wp + TAG_AW'(1);
      end
      if (w_tag_pop) r_tag_rp <= r_tag_rp + TAG_AW'(1);
      if (w_tag_push && !w_tag_pop)      r_tag_cnt <= r_tag_cnt + TAG_CW'(1);
      else if (!w_tag_push && w_tag_pop) r_tag_cnt <= r_tag_cnt - TAG_CW'(1);
    end
  end

endmodule
